multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle successor to the single-cycle main and ALU controllers for the RV32I datapath. One FSM sequences fetch, decode, execute, memory and writeback over a shared memory port. It generates all datapath enables and the 4-bit ALU control, and handles variable-latency memory with a timeout. It traps on illegal opcodes and bus timeouts, redirecting the PC to a fixed vector.

## Interface
Parameters:
- MAX_WAIT, 15: maximum mem_ready wait cycles per access before a bus-timeout trap; 1..255.
- WAIT_W, 8: width of the wait counter; must satisfy MAX_WAIT < 2^WAIT_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr  in  32  instruction register contents; stable from the cycle after IRWrite.
- mem_ready  in  1  memory completes the current access this cycle.
- alu_zero  in  1  ALU result is zero.
- alu_lt  in  1  ALU result bit 0 (signed-less-than for ALUCnt 0111).
- mem_req  out  1  memory access request.
- MemRead / MemWrite  out  1 each  access direction; valid only while mem_req = 1.
- IorD  out  1  address select: 0 = PC, 1 = ALU result.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  load PC.
- PCSrc  out  2  PC source: 00 = PC+4, 01 = branch/JAL target, 10 = ALU result (JALR, bit 0 cleared), 11 = trap vector.
- RegWrite  out  1  register-file write.
- WBSel  out  2  writeback source: 00 = ALU, 01 = memory data, 10 = PC+4, 11 = immediate (LUI).
- ALUsrcB  out  1  0 = rs2, 1 = immediate.
- ALUCnt  out  4  ALU operation code.
- trap  out  1  one-cycle pulse on trap entry.
- trap_cause  out  2  01 = illegal opcode, 10 = bus timeout; holds until the next trap.
- state  out  3  current FSM state, for debug.

## Operation
- State encoding: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, TRAP 6.
- IDLE: all outputs 0; goes to FETCH next cycle.
- FETCH: mem_req = MemRead = 1, IorD = 0.
  - On mem_ready: IRWrite = 1, PCWrite = 1, PCSrc = 00; go to DECODE.
- DECODE: decode instr[6:0]; go to EXEC for legal opcodes.
  - Illegal opcode: go to TRAP when CTRL_ILLEGAL_TRAP_EN is defined, otherwise go to FETCH.
- EXEC, per class:
  - R (0110011): ALUsrcB = 0 → WB.
  - I-ALU (0010011): ALUsrcB = 1 → WB.
  - LOAD (0000011) / STORE (0100011): ALUsrcB = 1, ALUCnt = 0010 → MEM.
  - LUI (0110111): → WB.
  - BRANCH (1100011): ALUsrcB = 0; PCWrite when taken, PCSrc = 01 → FETCH.
    - beq: taken when alu_zero. bne: taken when !alu_zero.
    - blt: taken when alu_lt. bge: taken when !alu_lt.
  - JAL (1101111): RegWrite = 1, WBSel = 10, PCWrite = 1, PCSrc = 01 → FETCH.
  - JALR (1100111): RegWrite = 1, WBSel = 10, PCWrite = 1, PCSrc = 10, ALUCnt = 0010 → FETCH.
- MEM: mem_req = 1, IorD = 1, MemRead for loads, MemWrite for stores.
  - On mem_ready: loads go to WB, stores go to FETCH.
- WB: RegWrite = 1; WBSel = 01 for loads, 11 for LUI, else 00 → FETCH.
- TRAP: trap = 1, PCWrite = 1, PCSrc = 11 → FETCH.
- ALUCnt decode from funct3/funct7:
  - add 0010, sub 0110, sll 1101, xor 1100, srl 1110, sra 1000, or 0001, and 0000.
  - Branches: beq/bne 0110, blt/bge 0111.
  - In the I-ALU class, funct3 000 always decodes to add.
  - Undefined funct3/funct7 combinations in the R or I-ALU class count as illegal.
- Wait counter:
  - Clears on entry to FETCH and MEM; increments each cycle mem_req = 1 and mem_ready = 0.
  - If it reaches MAX_WAIT with mem_ready still 0: drop mem_req, go to TRAP, trap_cause = 10.
  - mem_ready wins over timeout in the same cycle.

## Timing
- All outputs are decoded from registered state plus instr; no outputs are combinational from mem_ready except IRWrite/PCWrite in FETCH and the state advance in MEM.
- Reset: state = IDLE, wait counter = 0, trap_cause = 00, every output 0.
- Reset mid-access drops mem_req on the next edge; no write completes.
- Instruction cycles with zero-wait memory:
  - R, I-ALU, LUI: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH, JAL, JALR: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- An illegal opcode costs FETCH + DECODE + TRAP (3 cycles) with the macro defined.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an illegal opcode or funct combination enters TRAP with trap_cause = 01.
- Not defined: the illegal instruction retires as a NOP (DECODE → FETCH, no writes) and trap_cause is never 01.
- Bus-timeout trapping is present in both builds.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) with mem_ready tied to 1: states 0→1→2→3→5→1; ALUCnt = 0010 in EXEC; RegWrite pulses once in WB.
- lw (0x0000A183) with mem_ready low 3 cycles in MEM: MEM held 4 cycles, then WB with WBSel = 01; total 8 cycles.
- beq with alu_zero = 1, then with alu_zero = 0: PCWrite in EXEC with PCSrc = 01 in the first case only; ALUCnt = 0110 in both.
- Opcode 0x7F with the macro defined: trap pulses one cycle, trap_cause = 01, PCSrc = 11; without the macro there is no trap and no RegWrite/MemWrite.
- mem_ready held low in FETCH with MAX_WAIT = 15: after 15 wait cycles the FSM enters TRAP with trap_cause = 10 and mem_req = 0; a repeat with mem_ready rising on the 15th wait cycle proceeds normally with no trap.
- rst asserted in MEM during a store wait: the next state is IDLE, MemWrite = 0, and no completion is observed.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over one memory port.
// Define CTRL_ILLEGAL_TRAP_EN to trap on illegal instructions; otherwise they retire as NOPs.
module multicycle_control #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_lt,
    output logic        mem_req,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [1:0]  PCSrc,
    output logic        RegWrite,
    output logic [1:0]  WBSel,
    output logic        ALUsrcB,
    output logic [3:0]  ALUCnt,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);
    localparam logic [6:0] F7_ALT = 7'b0100000;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic [1:0]        cause_q, cause_d;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic is_r, is_i, is_load, is_store, is_lui, is_br, is_jal, is_jalr;
    logic arith_ok, legal, br_taken, miss;
    logic [3:0] arith_cnt, br_cnt;
    logic unused_instr_bits;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign is_r     = (opcode == 7'b0110011);
    assign is_i     = (opcode == 7'b0010011);
    assign is_load  = (opcode == 7'b0000011);
    assign is_store = (opcode == 7'b0100011);
    assign is_lui   = (opcode == 7'b0110111);
    assign is_br    = (opcode == 7'b1100011);
    assign is_jal   = (opcode == 7'b1101111);
    assign is_jalr  = (opcode == 7'b1100111);
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
    assign wait_inc = wait_q + 1'b1;

    // Shared R / I-ALU decode; funct7 only qualifies immediates for the shift forms.
    always_comb begin
        arith_cnt = 4'b0010;
        arith_ok  = 1'b0;
        case (funct3)
            3'b000: begin
                arith_cnt = (is_r && funct7 == F7_ALT) ? 4'b0110 : 4'b0010;
                arith_ok  = is_i || funct7 == 7'd0 || funct7 == F7_ALT;
            end
            3'b001: begin arith_cnt = 4'b1101; arith_ok = (funct7 == 7'd0); end
            3'b100: begin arith_cnt = 4'b1100; arith_ok = is_i || funct7 == 7'd0; end
            3'b101: begin
                arith_cnt = (funct7 == F7_ALT) ? 4'b1000 : 4'b1110;
                arith_ok  = funct7 == 7'd0 || funct7 == F7_ALT;
            end
            3'b110: begin arith_cnt = 4'b0001; arith_ok = is_i || funct7 == 7'd0; end
            3'b111: begin arith_cnt = 4'b0000; arith_ok = is_i || funct7 == 7'd0; end
            default: begin arith_cnt = 4'b0010; arith_ok = 1'b0; end
        endcase
    end

    assign legal = ((is_r || is_i) && arith_ok) || is_load || is_store || is_lui
                   || is_br || is_jal || is_jalr;
    assign br_cnt = funct3[2] ? 4'b0111 : 4'b0110;

    always_comb begin
        case (funct3)
            3'b000:  br_taken = alu_zero;
            3'b001:  br_taken = !alu_zero;
            3'b100:  br_taken = alu_lt;
            3'b101:  br_taken = !alu_lt;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        mem_req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0;
        IRWrite = 1'b0; PCWrite = 1'b0; PCSrc = 2'b00; RegWrite = 1'b0;
        WBSel = 2'b00; ALUsrcB = 1'b0; ALUCnt = 4'b0000; trap = 1'b0;
        state_d = state_q;
        wait_d  = wait_q;
        cause_d = cause_q;
        miss    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    miss = 1'b1;
                    if (wait_inc == MAX_W) begin
                        state_d = S_TRAP;
                        cause_d = 2'b10;
                    end
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
                    cause_d = 2'b01;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                if (is_r) begin
                    ALUCnt = arith_cnt;
                end else if (is_i) begin
                    ALUsrcB = 1'b1;
                    ALUCnt  = arith_cnt;
                end else if (is_load || is_store) begin
                    ALUsrcB = 1'b1;
                    ALUCnt  = 4'b0010;
                    state_d = S_MEM;
                end else if (is_br) begin
                    ALUCnt  = br_cnt;
                    state_d = S_FETCH;
                    if (br_taken) begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'b01;
                    end
                end else if (is_jal) begin
                    RegWrite = 1'b1; WBSel = 2'b10; PCWrite = 1'b1; PCSrc = 2'b01;
                    state_d  = S_FETCH;
                end else if (is_jalr) begin
                    RegWrite = 1'b1; WBSel = 2'b10; PCWrite = 1'b1; PCSrc = 2'b10;
                    ALUCnt   = 4'b0010;
                    state_d  = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemRead  = is_load;
                MemWrite = is_store;
                if (mem_ready) begin
                    state_d = is_load ? S_WB : S_FETCH;
                end else begin
                    miss = 1'b1;
                    if (wait_inc == MAX_W) begin
                        state_d = S_TRAP;
                        cause_d = 2'b10;
                    end
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                WBSel    = is_load ? 2'b01 : (is_lui ? 2'b11 : 2'b00);
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                trap    = 1'b1;
                PCWrite = 1'b1;
                PCSrc   = 2'b11;
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        if (miss) wait_d = wait_inc;
        // Any state change restarts the count, so each FETCH/MEM entry begins at zero.
        if (state_d != state_q) wait_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    assign state      = state_q;
    assign trap_cause = cause_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expectations queued, then replayed and compared.
module tb_multicycle_control;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, mem_ready, alu_zero, alu_lt;
    logic [31:0] instr;
    logic mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, ALUsrcB, trap;
    logic [1:0] PCSrc, WBSel, trap_cause;
    logic [3:0] ALUCnt;
    logic [2:0] state;

    multicycle_control #(.MAX_WAIT(15), .WAIT_W(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_req(mem_req), .MemRead(MemRead),
        .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .WBSel(WBSel), .ALUsrcB(ALUsrcB),
        .ALUCnt(ALUCnt), .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    logic [21:0] obs;
    assign obs = {state, mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
                  RegWrite, WBSel, ALUsrcB, ALUCnt, trap, trap_cause};

    typedef struct {
        logic        r;
        logic        rdy;
        logic        z;
        logic        lt;
        logic [31:0] ins;
        logic [21:0] exp;
        int          tag;
    } step_t;

    step_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          tag = 0;
    logic [1:0]  cur_cause = 2'b00;
    logic [31:0] cur_ins = 32'h0;

    function automatic logic [21:0] ev(input logic [2:0] st, input logic req = 1'b0,
            input logic rd = 1'b0, input logic wr = 1'b0, input logic iord = 1'b0,
            input logic irw = 1'b0, input logic pcw = 1'b0, input logic [1:0] pcs = 2'b00,
            input logic rw = 1'b0, input logic [1:0] wbs = 2'b00, input logic srcb = 1'b0,
            input logic [3:0] cnt = 4'b0000, input logic tr = 1'b0);
        return {st, req, rd, wr, iord, irw, pcw, pcs, rw, wbs, srcb, cnt, tr, cur_cause};
    endfunction

    task automatic push(input logic r, input logic rdy, input logic z, input logic lt,
                        input logic [21:0] e);
        step_t s;
        s.r = r; s.rdy = rdy; s.z = z; s.lt = lt; s.ins = cur_ins; s.exp = e; s.tag = tag;
        tag++;
        sb.push_back(s);
    endtask

    task automatic run(input string name);
        step_t s;
        int n;
        n = 0;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst = s.r; mem_ready = s.rdy; alu_zero = s.z; alu_lt = s.lt; instr = s.ins;
            @(negedge clk);
            checks++;
            n++;
            assert (obs === s.exp) else begin
                errors++;
                $error("FAIL step %0d observed %h expected %h", s.tag, obs, s.exp);
            end
            @(posedge clk);
            #1;
        end
        $display("txn %s instr %h cycles %0d", name, cur_ins, n);
    endtask

    task automatic fetch_ok();
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd1), .req(1'b1), .rd(1'b1), .irw(1'b1), .pcw(1'b1)));
    endtask
    task automatic fetch_miss();
        push(1'b0, 1'b0, 1'b0, 1'b0, ev(.st(3'd1), .req(1'b1), .rd(1'b1)));
    endtask
    task automatic decode();
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd2)));
    endtask

    task automatic do_alu(input logic [31:0] ins, input logic imm, input logic [3:0] cnt);
        cur_ins = ins;
        fetch_ok(); decode();
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd3), .srcb(imm), .cnt(cnt)));
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd5), .rw(1'b1)));
        run("alu");
    endtask

    task automatic do_br(input logic [31:0] ins, input logic z, input logic lt,
                         input logic [3:0] cnt, input logic taken);
        cur_ins = ins;
        fetch_ok(); decode();
        if (taken) push(1'b0, 1'b1, z, lt, ev(.st(3'd3), .pcw(1'b1), .pcs(2'b01), .cnt(cnt)));
        else       push(1'b0, 1'b1, z, lt, ev(.st(3'd3), .cnt(cnt)));
        run("branch");
    endtask

    task automatic do_illegal(input logic [31:0] ins);
        cur_ins = ins;
        fetch_ok(); decode();
`ifdef CTRL_ILLEGAL_TRAP_EN
        cur_cause = 2'b01;
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd6), .pcw(1'b1), .pcs(2'b11), .tr(1'b1)));
`endif
        run("illegal");
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0; instr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        push(1'b1, 1'b0, 1'b0, 1'b0, ev(.st(3'd0)));
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd0)));
        run("reset");

        do_alu(32'h002081B3, 1'b0, 4'b0010);   // add
        do_alu(32'h402081B3, 1'b0, 4'b0110);   // sub
        do_alu(32'h00108093, 1'b1, 4'b0010);   // addi
        do_alu(32'h4010D093, 1'b1, 4'b1000);   // srai
        do_alu(32'h0020E1B3, 1'b0, 4'b0001);   // or

        // lw with three wait cycles in MEM
        cur_ins = 32'h0000A183;
        fetch_ok(); decode();
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd3), .srcb(1'b1), .cnt(4'b0010)));
        repeat (3) push(1'b0, 1'b0, 1'b0, 1'b0, ev(.st(3'd4), .req(1'b1), .rd(1'b1), .iord(1'b1)));
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd4), .req(1'b1), .rd(1'b1), .iord(1'b1)));
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd5), .rw(1'b1), .wbs(2'b01)));
        run("lw");

        // lui
        cur_ins = 32'h000011B7;
        fetch_ok(); decode();
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd3)));
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd5), .rw(1'b1), .wbs(2'b11)));
        run("lui");

        do_br(32'h00208063, 1'b1, 1'b0, 4'b0110, 1'b1);  // beq taken
        do_br(32'h00208063, 1'b0, 1'b0, 4'b0110, 1'b0);  // beq not taken
        do_br(32'h00209063, 1'b0, 1'b0, 4'b0110, 1'b1);  // bne taken
        do_br(32'h0020C063, 1'b0, 1'b1, 4'b0111, 1'b1);  // blt taken
        do_br(32'h0020D063, 1'b0, 1'b1, 4'b0111, 1'b0);  // bge not taken

        cur_ins = 32'h0000006F;  // jal
        fetch_ok(); decode();
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd3), .rw(1'b1), .wbs(2'b10), .pcw(1'b1), .pcs(2'b01)));
        run("jal");
        cur_ins = 32'h00008067;  // jalr
        fetch_ok(); decode();
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd3), .rw(1'b1), .wbs(2'b10), .pcw(1'b1),
                                         .pcs(2'b10), .cnt(4'b0010)));
        run("jalr");

        do_illegal(32'h0000007F);
        do_illegal(32'h0020A1B3);  // slt is not supported by this ALU

        // fetch timeout: fifteen misses then TRAP
        cur_ins = 32'h002081B3;
        repeat (15) fetch_miss();
        cur_cause = 2'b10;
        push(1'b0, 1'b0, 1'b0, 1'b0, ev(.st(3'd6), .pcw(1'b1), .pcs(2'b11), .tr(1'b1)));
        run("fetch_timeout");

        // ready arrives on the fifteenth fetch cycle: no trap
        repeat (14) fetch_miss();
        fetch_ok(); decode();
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd3), .cnt(4'b0010)));
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd5), .rw(1'b1)));
        run("fetch_late_ready");

        // reset during a store wait
        cur_ins = 32'h0020A023;
        fetch_ok(); decode();
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd3), .srcb(1'b1), .cnt(4'b0010)));
        repeat (2) push(1'b0, 1'b0, 1'b0, 1'b0, ev(.st(3'd4), .req(1'b1), .wr(1'b1), .iord(1'b1)));
        push(1'b1, 1'b0, 1'b0, 1'b0, ev(.st(3'd4), .req(1'b1), .wr(1'b1), .iord(1'b1)));
        cur_cause = 2'b00;
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd0)));
        run("sw_reset");

        // store completing normally after recovery
        fetch_ok(); decode();
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd3), .srcb(1'b1), .cnt(4'b0010)));
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd4), .req(1'b1), .wr(1'b1), .iord(1'b1)));
        push(1'b0, 1'b1, 1'b0, 1'b0, ev(.st(3'd1), .req(1'b1), .rd(1'b1), .irw(1'b1), .pcw(1'b1)));
        run("sw");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
